// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC,
// sequential step, HALT opcode location and the queue entry layout.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
  localparam int DEF_PC_STEP = 4;

  // Opcode field of an instruction word and the value that stops fetching
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 6'b111111;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_q_if.sv
// Bus bundle of the fetch stage: instruction-memory read port, redirect input
// and the decode-side valid/ready channel.
//
// Handshake: id_valid/id_instr/id_pc/id_pc_next are driven by the fetch stage,
// id_ready by decode. A transfer happens on every rising edge where
// id_valid && id_ready. Payload is only meaningful while id_valid is high; it
// keeps its last value otherwise. imem_req has no ready: memory always accepts
// and returns imem_rdata exactly one cycle after the request.
interface fetch_stage_q_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_next;
  logic              id_ready;
  logic [CW-1:0]     q_count;
  logic              halted;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_instr, id_pc, id_pc_next,
    input  id_ready,
    output q_count, halted
  );

  // Environment side (memory, branch unit, decode)
  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_instr, id_pc, id_pc_next,
    output id_ready,
    input  q_count, halted
  );

endinterface

// File: rtl/fetch_stage_q_queue.sv
// fetch_queue: synchronous FIFO of fetch entries. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
// Flush empties the queue and has priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Status flags and guarded push/pop
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = CW'(wr_ptr - rd_ptr);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush resets both pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage_q.sv
// fetch_stage_q: PC owner and instruction-fetch stage. Issues one read per
// cycle to a 1-cycle-latency instruction memory, buffers returned words in a
// DEPTH-entry queue and presents the head to decode. A redirect flushes the
// queue and the in-flight response and reloads the PC.
// Optional build macro: FETCH_HALT_EN -- a fetched HALT opcode stops fetching
// until reset.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input logic             clk,
  input logic             inicio,
  fetch_stage_q_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              running;
  logic              halted_q;
  logic              req;
  logic              push;
  logic              pop;
  logic [CW:0]       occ;
  logic [CW-1:0]     q_count;
  logic              q_full;
  logic              q_empty;
  entry_t            q_head;
  entry_t            held;
  entry_t            head_view;
  entry_t            push_data;
  logic [ADDR_W-1:0] target_pc;

  // Request decision: only issue when the queue can take the response
  // without counting on a pop this cycle
  always_comb begin
    occ       = {1'b0, q_count} + (CW+1)'(inflight);
    req       = running && !bus.redirect && !halted_q && (occ < (CW+1)'(DEPTH));
    target_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  end

  // Queue side controls; a redirect discards the response arriving this edge
  always_comb begin
    push            = inflight && !bus.redirect && !halted_q;
    pop             = bus.id_valid && bus.id_ready;
    push_data.instr = bus.imem_rdata;
    push_data.pc    = inflight_pc;
  end

  // PC, in-flight tracking and start-up flag
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      running     <= 1'b0;
    end else begin
      running <= 1'b1;
      if (bus.redirect) begin
        pc       <= target_pc;
        inflight <= 1'b0;
      end else begin
        inflight <= req;
        if (req) begin
          inflight_pc <= pc;
          pc          <= pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

`ifdef FETCH_HALT_EN
  // Sticky halt: set when a HALT word is pushed, cleared only by reset
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      halted_q <= 1'b0;
    end else if (push && (bus.imem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE)) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (inicio),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Last presented head, so decode-side payload holds while the queue is empty
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      held <= '0;
    end else if (!q_empty) begin
      held <= q_head;
    end
  end

  // Output drive; id_valid is gated combinationally by redirect
  always_comb begin
    head_view      = q_empty ? held : q_head;
    bus.imem_req   = req;
    bus.imem_addr  = pc;
    bus.id_valid   = !q_empty && !bus.redirect;
    bus.id_instr   = head_view.instr;
    bus.id_pc      = head_view.pc;
    bus.id_pc_next = head_view.pc + ADDR_W'(PC_STEP);
    bus.q_count    = q_count;
    bus.halted     = halted_q;
  end

  a_push_has_room: assert property (@(posedge clk) disable iff (!inicio)
    push |-> (!q_full || pop));

endmodule

// File: tb/tb_fetch_stage_q.sv
// Testbench for fetch_stage_q: cycle-level reference model built from queues,
// randomized ready/redirect/reset stimulus plus directed scenarios, and a
// second instance with a wrapping reset PC.
module tb_fetch_stage_q;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic inicio = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_q_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();
  fetch_stage_q_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) w_bus ();

  fetch_stage_q #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .inicio (inicio),
    .bus    (bus)
  );

  fetch_stage_q #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk    (clk),
    .inicio (inicio),
    .bus    (w_bus)
  );

  // ---------------- memory models ----------------
  logic [31:0] salt;
  logic [31:0] halt_addr;
  logic        halt_on;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_on && a == halt_addr) return 32'hFC00_0000;
    return a ^ salt;
  endfunction

  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
  always @(posedge clk) if (w_bus.imem_req) w_bus.imem_rdata <= w_bus.imem_addr;

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        exp_q[$];
  ent_t        m_last;
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_running;
  bit          m_inflight;
  bit          m_halted;

  // wrap-instance expectations
  logic [31:0] w_exp [4];
  bit          wrap_en;
  int          wn_req;
  int          wn_del;

  task automatic model_reset();
    m_pc       = 32'h0;
    m_ipc      = 32'h0;
    m_running  = 1'b0;
    m_inflight = 1'b0;
    m_halted   = 1'b0;
    m_last     = '0;
    exp_q.delete();
  endtask

  task automatic wrap_sample();
    if (w_bus.imem_req && wn_req < 3) begin
      check("wrap_imem_addr", w_bus.imem_addr, w_exp[wn_req]);
      wn_req++;
    end
    if (w_bus.id_valid && wn_del < 3) begin
      check("wrap_id_pc", w_bus.id_pc, w_exp[wn_del]);
      check("wrap_id_pc_next", w_bus.id_pc_next, w_exp[wn_del+1]);
      check("wrap_id_instr", w_bus.id_instr, w_exp[wn_del]);
      wn_del++;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, compare, advance the model across
  // the following rising edge, return at the next falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit   req;
    bit   valid;
    ent_t head;
    ent_t e;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.id_ready    = rdy;
    #1;
    req   = m_running && !redir && !m_halted && (exp_q.size() + int'(m_inflight) < DEPTH);
    valid = (exp_q.size() > 0) && !redir;
    head  = (exp_q.size() > 0) ? exp_q[0] : m_last;
    check("imem_req", bus.imem_req, req);
    check("imem_addr", bus.imem_addr, m_pc);
    check("id_valid", bus.id_valid, valid);
    check("id_instr", bus.id_instr, head.instr);
    check("id_pc", bus.id_pc, head.pc);
    check("id_pc_next", bus.id_pc_next, head.pc + 32'd4);
    check("q_count", bus.q_count, exp_q.size());
    check("halted", bus.halted, m_halted);
    if (wrap_en) wrap_sample();
    // model across the rising edge
    if (exp_q.size() > 0) m_last = exp_q[0];
    if (redir) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (valid && rdy) void'(exp_q.pop_front());
      if (m_inflight && !m_halted) begin
        e.instr = mem_word(m_ipc);
        e.pc    = m_ipc;
        exp_q.push_back(e);
`ifdef FETCH_HALT_EN
        if (e.instr[31:26] == 6'h3F) m_halted = 1'b1;
`endif
      end
      if (req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
      m_inflight = req;
    end
    m_running = 1'b1;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting at a falling edge, checked before any
  // rising edge occurs
  task automatic do_reset(input logic [31:0] new_salt);
    bus.redirect = 1'b0;
    inicio = 1'b0;
    #1;
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_q_count", bus.q_count, 0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    model_reset();
    salt = new_salt;
    @(negedge clk);
    inicio = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.redirect      = 1'b0;
    bus.redirect_pc   = '0;
    bus.id_ready      = 1'b0;
    w_bus.redirect    = 1'b0;
    w_bus.redirect_pc = '0;
    w_bus.id_ready    = 1'b1;
    salt      = 32'h0;
    halt_on   = 1'b0;
    halt_addr = 32'h8;
    wrap_en   = 1'b0;
    wn_req    = 0;
    wn_del    = 0;
    w_exp[0] = 32'hFFFF_FFF8;
    w_exp[1] = 32'hFFFF_FFFC;
    w_exp[2] = 32'h0000_0000;
    w_exp[3] = 32'h0000_0004;
    model_reset();
    @(negedge clk);

    // Streaming with word == address, plus the wrapping instance
    do_reset(32'h0);
    wrap_en = 1'b1;
    repeat (12) step(1'b0, 32'h0, 1'b1);
    wrap_en = 1'b0;
    check("wrap_requests_seen", wn_req, 3);
    check("wrap_deliveries_seen", wn_del, 3);

    // Decode stalled from start: fill to DEPTH, then drain and resume
    do_reset(32'h1357_0000);
    repeat (10) step(1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b0, 32'h0, 1'b1);

    // Redirect to 0x103 with three queued entries and one in flight
    do_reset(32'h0246_8000);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h103, 1'b0);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Redirect during full-rate flow (pop and push on the same edge),
    // then back-to-back redirects
    repeat (6) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h40A, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // HALT word at 0x8, then a redirect, then reset
    do_reset(32'h0);
    halt_on = 1'b1;
    repeat (10) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h50, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    do_reset(32'h0);
    halt_on = 1'b0;
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // Randomized ready / redirect / mid-operation reset
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom & 32'h03FF_FFFF);
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
